tsc_mc_control: RTL and testbench

- Multi-cycle control sequencer for the TSC microcomputer datapath (PC, instruction memory, 4x16 register file, ALU, output_port).
- Each cycle it latches the fetched instruction, decodes the supported TSC subset (ADD, WWD, ADI, LHI, JMP) and drives per-state control strobes to the datapath.
- Stalls on cpu_enable and stops at a programmed end address.
- Replaces ad-hoc single-cycle control; sits between the instruction memory read port and the datapath muxes/enables.

---
 rtl/tsc_mc_control.sv | 161 ++++++++++++++++
 tb/tb_tsc_mc_control.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/tsc_mc_control.sv
// Multi-cycle control sequencer for the TSC datapath: FETCH/DECODE/EXEC/WB/DONE over ADD, ADI, LHI, WWD, JMP.
// Optional retired-instruction counter output num_inst is enabled by defining TSC_NUM_INST_EN.
module tsc_mc_control #(
    parameter int WORD_SIZE = 16,
    parameter int PC_BITS   = 8,
    parameter int PC_END    = 27
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_enable,
    input  logic                 wwd_enable,
    input  logic [WORD_SIZE-1:0] instr,
    input  logic [PC_BITS-1:0]   pc_cur,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src_jmp,
    output logic                 reg_write,
    output logic                 reg_dst_rt,
    output logic                 alu_src_imm,
    output logic [1:0]           alu_op,
    output logic                 out_strobe,
    output logic [1:0]           rs,
    output logic [1:0]           rt,
    output logic [1:0]           rd,
    output logic [7:0]           imm,
    output logic [11:0]          target,
`ifdef TSC_NUM_INST_EN
    output logic [WORD_SIZE-1:0] num_inst,
`endif
    output logic                 illegal,
    output logic                 done
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [PC_BITS-1:0] PC_LAST = PC_BITS'(PC_END);

    state_t               state;
    state_t               state_next;
    logic [WORD_SIZE-1:0] ir;

    logic [3:0] op;
    logic [5:0] func;
    logic       is_add, is_adi, is_lhi, is_wwd, is_jmp;
    logic       has_wb, unsupported;
    logic       active, at_end, last_cycle;

    assign op     = ir[15:12];
    assign func   = ir[5:0];
    assign is_add = (op == 4'hF) && (func == 6'd0);
    assign is_wwd = (op == 4'hF) && (func == 6'd28);
    assign is_adi = (op == 4'h4);
    assign is_lhi = (op == 4'h6);
    assign is_jmp = (op == 4'h9);

    assign has_wb      = is_add | is_adi | is_lhi;
    assign unsupported = ~(has_wb | is_wwd | is_jmp);

    // Strobes only fire while running; reset kills the in-flight instruction's writes.
    assign active     = cpu_enable && !reset;
    assign at_end     = (pc_cur == PC_LAST);
    assign last_cycle = ((state == S_EXEC) && !has_wb) || (state == S_WB);

    assign rs     = ir[11:10];
    assign rt     = ir[9:8];
    assign rd     = ir[7:6];
    assign imm    = ir[7:0];
    assign target = ir[11:0];
    assign done   = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (cpu_enable) begin
            case (state)
                S_FETCH:  state_next = S_DECODE;
                S_DECODE: state_next = S_EXEC;
                S_EXEC: begin
                    if (has_wb)      state_next = S_WB;
                    else if (at_end) state_next = S_DONE;
                    else             state_next = S_FETCH;
                end
                S_WB:     state_next = at_end ? S_DONE : S_FETCH;
                S_DONE:   state_next = S_DONE;
                default:  state_next = S_FETCH;
            endcase
        end
    end

    always_comb begin
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src_jmp  = 1'b0;
        reg_write   = 1'b0;
        reg_dst_rt  = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = 2'b00;
        out_strobe  = 1'b0;
        if (active) begin
            case (state)
                S_FETCH: ir_write = 1'b1;
                S_EXEC: begin
                    if (!has_wb) begin
                        pc_write   = !at_end;
                        pc_src_jmp = is_jmp;
                        out_strobe = is_wwd && wwd_enable;
                    end
                end
                S_WB: begin
                    reg_write   = 1'b1;
                    reg_dst_rt  = !is_add;
                    alu_src_imm = !is_add;
                    alu_op      = is_lhi ? 2'b01 : 2'b00;
                    pc_write    = !at_end;
                end
                default: ;
            endcase
        end
    end

    // IR only captures in FETCH, so later changes on instr never reach decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= '0;
        end else if (cpu_enable && (state == S_FETCH)) begin
            ir <= instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal <= 1'b0;
        end else if (cpu_enable && (state == S_EXEC) && unsupported) begin
            illegal <= 1'b1;
        end
    end

`ifdef TSC_NUM_INST_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            num_inst <= '0;
        end else if (pc_write || (active && last_cycle && at_end)) begin
            num_inst <= num_inst + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tsc_mc_control.sv
// Scoreboard bench for tsc_mc_control: per-cycle expected strobe vectors are queued at drive time
// and compared on the falling edge; IR field outputs are checked directly after the cycle.
module tb_tsc_mc_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_enable = 1'b0;
    logic        wwd_enable = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic [7:0]  pc_cur = 8'd0;
    logic        ir_write, pc_write, pc_src_jmp, reg_write, reg_dst_rt, alu_src_imm;
    logic [1:0]  alu_op;
    logic        out_strobe;
    logic [1:0]  rs, rt, rd;
    logic [7:0]  imm;
    logic [11:0] target;
    logic        illegal, done;
`ifdef TSC_NUM_INST_EN
    logic [15:0] num_inst;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_inst = 0;

    typedef struct {
        string       tag;
        logic [10:0] exp;
    } sb_item_t;

    sb_item_t sb[$];

    tsc_mc_control #(.WORD_SIZE(16), .PC_BITS(8), .PC_END(27)) dut (
        .clk(clk), .reset(reset), .cpu_enable(cpu_enable), .wwd_enable(wwd_enable),
        .instr(instr), .pc_cur(pc_cur),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src_jmp(pc_src_jmp),
        .reg_write(reg_write), .reg_dst_rt(reg_dst_rt), .alu_src_imm(alu_src_imm),
        .alu_op(alu_op), .out_strobe(out_strobe),
        .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
`ifdef TSC_NUM_INST_EN
        .num_inst(num_inst),
`endif
        .illegal(illegal), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {ir_write, pc_write, pc_src_jmp, reg_write, reg_dst_rt, alu_src_imm, alu_op, out_strobe, illegal, done}
    function automatic logic [10:0] e(input bit iw, pw, pj, rw, rdt, ai, input bit [1:0] aop,
                                      input bit os, il, dn);
        return {iw, pw, pj, rw, rdt, ai, aop, os, il, dn};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_item_t it;
            it = sb.pop_front();
            chk(it.tag, {21'd0, ir_write, pc_write, pc_src_jmp, reg_write, reg_dst_rt,
                         alu_src_imm, alu_op, out_strobe, illegal, done}, {21'd0, it.exp});
        end
    end

    task automatic cyc(input string tag, input logic rst, en, wwd, input logic [15:0] ins,
                       input logic [7:0] pc, input logic [10:0] exp);
        sb_item_t it;
        @(posedge clk);
        #1;
        reset      = rst;
        cpu_enable = en;
        wwd_enable = wwd;
        instr      = ins;
        pc_cur     = pc;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
        if (rst)         exp_inst = 0;
        else if (exp[9]) exp_inst++;
        @(negedge clk);
        #1;
    endtask

    localparam logic [10:0] Z = 11'd0;

    initial begin
        // Reset: first cycle leaves registers unknown, so only the second is scored.
        @(posedge clk);
        #1;
        cyc("reset", 1, 1, 0, 16'h6101, 0, Z);

        // Unsupported opcode, then reset aborting an ADD in EXEC.
        cyc("ill_fetch",  0, 1, 0, 16'hA000, 0, e(1,0,0,0,0,0,2'b00,0,0,0));
        cyc("ill_decode", 0, 1, 0, 16'h6101, 0, Z);
        cyc("ill_exec",   0, 1, 0, 16'h6101, 0, e(0,1,0,0,0,0,2'b00,0,0,0));
        cyc("add_fetch",  0, 1, 0, 16'hF6C0, 0, e(1,0,0,0,0,0,2'b00,0,1,0));
        cyc("add_decode", 0, 1, 0, 16'h0000, 0, e(0,0,0,0,0,0,2'b00,0,1,0));
        cyc("add_rst",    1, 1, 0, 16'h0000, 0, e(0,0,0,0,0,0,2'b00,0,1,0));

        // LHI $1,1; instr toggles after FETCH to show decode uses the latched IR.
        cyc("lhi_fetch",  0, 1, 0, 16'h6101, 0, e(1,0,0,0,0,0,2'b00,0,0,0));
        cyc("lhi_decode", 0, 1, 0, 16'hA000, 0, Z);
        chk("lhi_rt",  {30'd0, rt}, 32'd1);
        chk("lhi_imm", {24'd0, imm}, 32'h01);
        cyc("lhi_exec",   0, 1, 0, 16'hF01C, 0, Z);
        cyc("lhi_wb",     0, 1, 0, 16'h9015, 0, e(0,1,0,1,1,1,2'b01,0,0,0));

        // WWD with and without the output enable.
        cyc("wwd1_fetch",  0, 1, 1, 16'hF01C, 0, e(1,0,0,0,0,0,2'b00,0,0,0));
        cyc("wwd1_decode", 0, 1, 1, 16'h0000, 0, Z);
        cyc("wwd1_exec",   0, 1, 1, 16'h0000, 0, e(0,1,0,0,0,0,2'b00,1,0,0));
        cyc("wwd0_fetch",  0, 1, 0, 16'hF01C, 0, e(1,0,0,0,0,0,2'b00,0,0,0));
        cyc("wwd0_decode", 0, 1, 0, 16'h0000, 0, Z);
        cyc("wwd0_exec",   0, 1, 0, 16'h0000, 0, e(0,1,0,0,0,0,2'b00,0,0,0));

        // JMP 21.
        cyc("jmp_fetch",  0, 1, 0, 16'h9015, 0, e(1,0,0,0,0,0,2'b00,0,0,0));
        cyc("jmp_decode", 0, 1, 0, 16'h0000, 0, Z);
        cyc("jmp_exec",   0, 1, 0, 16'h0000, 0, e(0,1,1,0,0,0,2'b00,0,0,0));
        chk("jmp_target", {20'd0, target}, 32'h015);

        // ADD $3,$1,$2 with a 5-cycle stall in DECODE.
        cyc("add_fetch2", 0, 1, 0, 16'hF6C0, 0, e(1,0,0,0,0,0,2'b00,0,0,0));
        for (int i = 0; i < 5; i++)
            cyc($sformatf("stall%0d", i), 0, 0, 1, 16'hF01C, 0, Z);
        cyc("add_decode2", 0, 1, 0, 16'hF01C, 0, Z);
        cyc("add_exec2",   0, 1, 0, 16'hF01C, 0, Z);
        cyc("add_wb2",     0, 1, 0, 16'hF01C, 0, e(0,1,0,1,0,0,2'b00,0,0,0));
        chk("add_rd", {30'd0, rd}, 32'd3);
        chk("add_rs", {30'd0, rs}, 32'd1);

        // Last instruction at PC_END, then DONE holds.
        cyc("end_fetch",  0, 1, 1, 16'hF01C, 27, e(1,0,0,0,0,0,2'b00,0,0,0));
        cyc("end_decode", 0, 1, 1, 16'h0000, 27, Z);
        cyc("end_exec",   0, 1, 1, 16'h0000, 27, e(0,0,0,0,0,0,2'b00,1,0,0));
        exp_inst++;
        for (int i = 0; i < 3; i++)
            cyc($sformatf("done%0d", i), 0, 1, 1, 16'h6101, 0, e(0,0,0,0,0,0,2'b00,0,0,1));
        cyc("done_stall", 0, 0, 1, 16'h6101, 0, e(0,0,0,0,0,0,2'b00,0,0,1));
`ifdef TSC_NUM_INST_EN
        chk("num_inst", {16'd0, num_inst}, exp_inst);
`endif
        cyc("done_rst",   1, 1, 0, 16'h6101, 0, e(0,0,0,0,0,0,2'b00,0,0,1));
        cyc("post_fetch", 0, 1, 0, 16'h6101, 0, e(1,0,0,0,0,0,2'b00,0,0,0));

        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
